// File: rtl/uart_tx_fsm.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Define UART_TX_HOLD_EN to add a one-entry holding register for gapless back-to-back frames.
//
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | driving the start bit (0)
// DATA   | driving data[bit_cnt]
// PARITY | driving the parity bit of the latched byte
// STOP   | driving the stop bit (1)
module uart_tx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESC_W-1:0]    Prescale,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  tx_ready
);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_n;
  logic [PRESC_W-1:0]    edge_q, edge_n, presc_q, presc_n, presc_in;
  logic [BIT_W-1:0]      bit_q, bit_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic                  par_en_q, par_en_n, par_typ_q, par_typ_n;
  logic                  tx_n, busy_n, last_edge, accept;

`ifdef UART_TX_HOLD_EN
  logic                  hold_full_q, hold_full_n;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_n;
  logic                  hold_par_en_q, hold_par_en_n, hold_par_typ_q, hold_par_typ_n;
`endif

  assign presc_in  = (Prescale == '0) ? PRESC_W'(1) : Prescale;
  assign last_edge = (edge_q == presc_q - PRESC_W'(1));

`ifdef UART_TX_HOLD_EN
  assign tx_ready = ~hold_full_q;
`else
  assign tx_ready = ~busy;
`endif
  assign accept = Data_Valid & tx_ready;

  always_comb begin
    state_n   = state_q;
    edge_n    = edge_q;
    bit_n     = bit_q;
    data_n    = data_q;
    par_en_n  = par_en_q;
    par_typ_n = par_typ_q;
    presc_n   = presc_q;
`ifdef UART_TX_HOLD_EN
    hold_full_n    = hold_full_q;
    hold_data_n    = hold_data_q;
    hold_par_en_n  = hold_par_en_q;
    hold_par_typ_n = hold_par_typ_q;
`endif

    if (state_q != IDLE) edge_n = last_edge ? '0 : edge_q + PRESC_W'(1);

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_n   = START;
          edge_n    = '0;
          bit_n     = '0;
          data_n    = P_DATA;
          par_en_n  = PAR_EN;
          par_typ_n = PAR_TYP;
          presc_n   = presc_in;
        end
      end
      START: begin
        if (last_edge) begin
          state_n = DATA;
          bit_n   = '0;
        end
      end
      DATA: begin
        if (last_edge) begin
          if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
            bit_n   = '0;
            state_n = par_en_q ? PARITY : STOP;
          end else begin
            bit_n = bit_q + BIT_W'(1);
          end
        end
      end
      PARITY: if (last_edge) state_n = STOP;
      STOP: begin
        if (last_edge) begin
          state_n = IDLE;
`ifdef UART_TX_HOLD_EN
          // Chain the next frame with no idle cycle: held entry first, else a same-edge request.
          if (hold_full_q) begin
            state_n     = START;
            bit_n       = '0;
            data_n      = hold_data_q;
            par_en_n    = hold_par_en_q;
            par_typ_n   = hold_par_typ_q;
            presc_n     = presc_in;
            hold_full_n = 1'b0;
          end else if (accept) begin
            state_n   = START;
            bit_n     = '0;
            data_n    = P_DATA;
            par_en_n  = PAR_EN;
            par_typ_n = PAR_TYP;
            presc_n   = presc_in;
          end
`endif
        end
      end
      default: state_n = IDLE;
    endcase

`ifdef UART_TX_HOLD_EN
    if (accept && (state_q != IDLE) && !((state_q == STOP) && last_edge)) begin
      hold_full_n    = 1'b1;
      hold_data_n    = P_DATA;
      hold_par_en_n  = PAR_EN;
      hold_par_typ_n = PAR_TYP;
    end
`endif

    // Line level is registered from the next state so it changes on the same edge as the state.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = data_n[bit_n];
      PARITY:  tx_n = (^data_n) ^ par_typ_n;
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      edge_q    <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      presc_q   <= '0;
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
`ifdef UART_TX_HOLD_EN
      hold_full_q    <= 1'b0;
      hold_data_q    <= '0;
      hold_par_en_q  <= 1'b0;
      hold_par_typ_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_n;
      edge_q    <= edge_n;
      bit_q     <= bit_n;
      data_q    <= data_n;
      par_en_q  <= par_en_n;
      par_typ_q <= par_typ_n;
      presc_q   <= presc_n;
      TX_OUT    <= tx_n;
      busy      <= busy_n;
`ifdef UART_TX_HOLD_EN
      hold_full_q    <= hold_full_n;
      hold_data_q    <= hold_data_n;
      hold_par_en_q  <= hold_par_en_n;
      hold_par_typ_q <= hold_par_typ_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Testbench for uart_tx_fsm: directed frames, a frame-decoding monitor and an expected-frame queue.
// Hold-register scenarios run when UART_TX_HOLD_EN is defined.
module tb_uart_tx_fsm;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA = '0;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = '0;
  logic       TX_OUT, busy, tx_ready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    int         presc;
  } frame_t;

  frame_t exp_q[$];

  uart_tx_fsm #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Prescale(Prescale),
    .TX_OUT(TX_OUT), .busy(busy), .tx_ready(tx_ready)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] p);
    frame_t f;
    f.data  = d;
    f.pe    = pe;
    f.pt    = pt;
    f.presc = (p == 0) ? 1 : int'(p);
    exp_q.push_back(f);
  endtask

  // Called just after a rising edge; returns just after the acceptance edge.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] p);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = p; Data_Valid = 1'b1;
    push_frame(d, pe, pt, p);
    @(posedge CLK); #1;
    Data_Valid = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      n++;
      @(negedge CLK);
    end
  endtask

  // Frame monitor: a low line outside a frame is a start bit; every slot is checked each cycle.
  initial begin : mon
    frame_t     f;
    logic [10:0] bits;
    int         ns;
    logic       obs;
    logic       aborted;
    forever begin
      @(negedge CLK);
      if (RST === 1'b0 && TX_OUT === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
          repeat (20) @(negedge CLK);
        end else begin
          f = exp_q.pop_front();
          bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) bits[i+1] = f.data[i];
          bits[9]  = f.pe ? ((^f.data) ^ f.pt) : 1'b1;
          bits[10] = 1'b1;
          ns = f.pe ? 11 : 10;
          aborted = 1'b0;
          for (int s = 0; s < ns; s++) begin
            obs = bits[s];
            for (int c = 0; c < f.presc; c++) begin
              if (s != 0 || c != 0) @(negedge CLK);
              if (RST !== 1'b0) begin
                aborted = 1'b1;
                break;
              end
              if (TX_OUT !== bits[s]) obs = TX_OUT;
            end
            if (aborted) break;
            check($sformatf("slot%0d_data%02h", s, f.data), obs, bits[s]);
          end
        end
      end
    end
  end

  initial begin : stim
    int n;
    int g;
    int k;
    repeat (2) @(posedge CLK); #1;
    check("rst_tx", TX_OUT, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", tx_ready, 1);
    RST = 1'b0;
    @(posedge CLK); #1;

    send(8'hA5, 1'b1, 1'b0, 6'd8);
    check("lat_tx", TX_OUT, 0);
    check("lat_busy", busy, 1);
    @(negedge CLK); count_busy(n);
    check("len_a5_even", n, 88);

    @(posedge CLK); #1;
    send(8'hA5, 1'b1, 1'b1, 6'd8);
    @(negedge CLK); count_busy(n);
    check("len_a5_odd", n, 88);

    @(posedge CLK); #1;
    send(8'hA5, 1'b0, 1'b0, 6'd8);
    @(negedge CLK); count_busy(n);
    check("len_a5_nopar", n, 80);

    @(posedge CLK); #1;
    send(8'h01, 1'b0, 1'b0, 6'd0);
    check("p0_lat_tx", TX_OUT, 0);
    @(negedge CLK); count_busy(n);
    check("len_presc0", n, 10);

`ifndef UART_TX_HOLD_EN
    // Data_Valid held high; inputs change mid-frame and must only affect the next frame.
    @(posedge CLK); #1;
    P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd4; Data_Valid = 1'b1;
    push_frame(8'h3C, 1'b0, 1'b0, 6'd4);
    @(posedge CLK); #1;
    check("dvh_lat_tx", TX_OUT, 0);
    repeat (10) @(posedge CLK); #1;
    P_DATA = 8'hFF; PAR_EN = 1'b1; PAR_TYP = 1'b1; Prescale = 6'd3;
    push_frame(8'hFF, 1'b1, 1'b1, 6'd3);
    @(negedge CLK); count_busy(n);
    check("dvh_len1", n, 30);
    g = 0;
    while (busy === 1'b0 && g < 50) begin
      g++;
      @(negedge CLK);
    end
    check("dvh_gap", g, 1);
    Data_Valid = 1'b0;
    count_busy(n);
    check("dvh_len2", n, 33);
`endif

    // Reset during data bit 4 at Prescale=16.
    @(posedge CLK); #1;
    send(8'h0F, 1'b0, 1'b0, 6'd16);
    repeat (85) @(posedge CLK); #1;
    check("pre_rst_tx", TX_OUT, 0);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("mid_rst_tx", TX_OUT, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", tx_ready, 1);
    RST = 1'b0;
    @(posedge CLK); #1;
    send(8'h96, 1'b1, 1'b1, 6'd3);
    @(negedge CLK); count_busy(n);
    check("len_after_rst", n, 33);

`ifdef UART_TX_HOLD_EN
    @(posedge CLK); #1;
    send(8'h55, 1'b0, 1'b0, 6'd4);
    check("h_ready_busy", tx_ready, 1);
    repeat (4) @(posedge CLK); #1;
    send(8'hAA, 1'b0, 1'b0, 6'd4);
    check("h_ready_full", tx_ready, 0);
    P_DATA = 8'h33; Data_Valid = 1'b1;
    @(posedge CLK); #1;
    Data_Valid = 1'b0;
    k = 6;
    while (tx_ready !== 1'b1 && k < 200) begin
      @(posedge CLK); #1;
      k++;
    end
    check("h_ready_edge", k, 40);
    check("h_gap_busy", busy, 1);
    check("h_gap_tx", TX_OUT, 0);
    @(negedge CLK); count_busy(n);
    check("h_len2", n, 40);
`endif

    repeat (30) @(posedge CLK);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fsm.md
Name: uart_tx_fsm

Overview:
- UART transmitter, the counterpart of the system's RX path; serializes one byte per frame onto TX_OUT.
- Frame format: start bit (0), 8 data bits LSB first, optional parity bit, one stop bit (1).
- Every bit is held for Prescale clock cycles.
- Sits between the system register/FIFO layer, which presents P_DATA with Data_Valid, and the serial pin.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESC_W, 6, width of the Prescale input.

Ports:
- CLK  input  1  system clock; all logic on rising edge
- RST  input  1  synchronous, active-high reset
- P_DATA  input  DATA_WIDTH  byte to transmit
- Data_Valid  input  1  request strobe; accepted only when tx_ready=1
- PAR_EN  input  1  1 = insert parity bit
- PAR_TYP  input  1  0 = even parity, 1 = odd parity
- Prescale  input  PRESC_W  clock cycles per bit; 0 is treated as 1
- TX_OUT  output  1  serial line, registered, idles high
- busy  output  1  registered; 1 while a frame is on the line
- tx_ready  output  1  1 = a Data_Valid in this cycle is accepted

Behaviour:
- Reset values: TX_OUT=1, busy=0, tx_ready=1; state IDLE; counters and data/hold registers cleared.
- RST has priority over all other inputs. Asserting RST mid-frame aborts the frame, and TX_OUT=1 from the next edge.
- States: IDLE, START, DATA, PARITY, STOP.
- Internal counters:
  - edge_cnt runs 0..Prescale-1.
  - bit_cnt counts bits within a state; for DATA it runs 0..DATA_WIDTH-1.
- Acceptance: at an edge where Data_Valid=1 and tx_ready=1, the block latches P_DATA, PAR_EN and PAR_TYP.
- Parity bit = XOR of the latched data, inverted when PAR_TYP=1. It is computed from the latched copy.
- Prescale is sampled at frame start and held for the whole frame.
- Latency: from the acceptance edge, the state is START, TX_OUT=0 and busy=1.
- Transitions (each takes place on the edge where edge_cnt==Prescale-1; edge_cnt then resets to 0):
  - START -> DATA.
  - DATA -> next bit, until bit_cnt==DATA_WIDTH-1; then -> PARITY if the latched PAR_EN=1, else -> STOP.
  - PARITY -> STOP.
  - STOP -> IDLE, or directly -> START when the optional feature is enabled and the hold register is full.
- TX_OUT per state: START=0; DATA=data[bit_cnt]; PARITY=parity bit; STOP=1; IDLE=1.
- Frame duration: (10 + latched PAR_EN) * Prescale cycles of busy=1.
- Without the optional feature:
  - tx_ready = ~busy.
  - Data_Valid while busy is ignored, with no error flag.
  - Back-to-back frames have at least one IDLE cycle between them: the stop bit completes, then there is 1 cycle with busy=0, then the next acceptance.
- Input changes: changes on P_DATA, PAR_EN, PAR_TYP or Prescale during a frame do not affect that frame.
- Data_Valid held high continuously: each accepted assertion sends exactly one frame. A new acceptance requires tx_ready=1 again; no edge detection.

Optional Feature:
- Macro: UART_TX_HOLD_EN.
- With the macro defined, the block has a one-entry holding register.
  - tx_ready = ~hold_full.
  - A Data_Valid accepted while busy=1 stores P_DATA, PAR_EN and PAR_TYP in the hold register and sets hold_full.
  - At the end of STOP with hold_full=1, the held entry moves to the shift register and the state goes directly to START, with zero idle cycles. hold_full clears on that same edge, so a new Data_Valid is accepted again from that edge.
  - If Data_Valid is accepted on the same edge that STOP completes with hold_full=0, the new data goes straight to START, again with no gap.
  - Reset clears hold_full.
- Without the macro: no hold register, and behaviour is as stated in Behaviour.

Test Plan:
- Prescale=8, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5, one Data_Valid pulse:
  - TX_OUT per 8-cycle slot = 0,1,0,1,0,0,1,0,1,0(parity),1.
  - busy=1 for exactly 88 cycles.
  - TX_OUT=0 and busy=1 are visible immediately after the acceptance edge.
- Same stimulus with PAR_TYP=1: parity slot = 1. With PAR_EN=0: 10 slots, busy=1 for 80 cycles, and no parity slot.
- Prescale=0 with P_DATA=0x01, PAR_EN=0: each bit lasts 1 cycle, the frame lasts 10 cycles, and TX_OUT=0,1,0,0,0,0,0,0,0,1.
- Data_Valid held high with P_DATA changing mid-frame (0x3C then 0xFF), without the macro:
  - First frame carries 0x3C unchanged.
  - Exactly one busy=0 cycle, then the next frame carries the P_DATA value present at that acceptance.
- RST=1 during DATA bit 4 (Prescale=16): after the next edge TX_OUT=1, busy=0, tx_ready=1. A new Data_Valid after RST deasserts starts a clean frame.
- With UART_TX_HOLD_EN, send 0x55 and, while busy, send 0xAA:
  - tx_ready=0 until the end of the first STOP.
  - The second start bit directly follows the first stop bit, with no idle cycle.
  - A third Data_Valid while hold_full=1 is ignored.
